lrelu_sequencer: RTL and testbench

- Sequences one leaky-ReLU lane over a contiguous vector held in the unified buffer. The vector is given as a source base address and a length.
- Each cycle the block issues one buffer read, feeds the returned word to an external leaky_relu lane, and writes the lane result to a destination base address.
- It sits between the host/instruction decoder (command side) and the unified buffer plus activation lane (datapath side).
- It also holds the leak-factor configuration register that drives the lane.

---
 rtl/lrelu_sequencer.sv | 137 +++++++++++++
 tb/tb_lrelu_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lrelu_sequencer.sv
// Streams a vector from the unified buffer through one leaky-ReLU lane and
// writes the results back, with a fixed two-cycle read-to-write pipeline.
module lrelu_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [DATA_W-1:0] cfg_leak,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] lr_in,
    output logic [DATA_W-1:0] lr_leak,
    input  logic [DATA_W-1:0] lr_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [LEN_W-1:0]   lenReg;
    logic [LEN_W-1:0]   issued;
    logic [ADDR_W-1:0]  dstPtr;
    logic               stage1Valid;
    logic               accept;

    assign accept  = (state == IDLE) && start;
    assign wr_data = lr_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // issued counts reads already launched, so it equals lenReg in the last ISSUE cycle
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued == lenReg) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!stage1Valid) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            lenReg  <= '0;
            issued  <= '0;
        end else begin
            busy  <= (stateNext != IDLE);
            done  <= (stateNext == DONE);
            rd_en <= (stateNext == ISSUE);
            if (accept) begin
                rd_addr <= src_base;
                lenReg  <= len;
                issued  <= LEN_W'(1);
            end else if (state == ISSUE && stateNext == ISSUE) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                issued  <= issued + LEN_W'(1);
            end
        end
    end

    // Write side trails the read side by two cycles; dstPtr walks the destination range
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1Valid <= 1'b0;
            lr_in       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            dstPtr      <= '0;
        end else begin
            stage1Valid <= rd_en;
            wr_en       <= stage1Valid;
            if (rd_en) begin
                lr_in <= rd_data;
            end
            if (accept) begin
                dstPtr <= dst_base;
            end else if (stage1Valid) begin
                wr_addr <= dstPtr;
                dstPtr  <= dstPtr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_leak <= '0;
        end else if (state == IDLE && cfg_we) begin
            lr_leak <= cfg_leak;
        end
    end

endmodule

// File: tb/tb_lrelu_sequencer.sv
// Directed bench for lrelu_sequencer: buffer and a registered leaky-ReLU lane
// are modelled here, and each cycle of each command is checked against hand values.
module tb_lrelu_sequencer;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [DATA_W-1:0] cfg_leak;
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] lr_in;
    logic [DATA_W-1:0] lr_leak;
    logic [DATA_W-1:0] lr_out = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] expData [8];
    int checks   = 0;
    int failures = 0;

    lrelu_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_leak(cfg_leak), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .lr_in(lr_in),
        .lr_leak(lr_leak), .lr_out(lr_out), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Read data is presented during the read cycle and captured at its closing edge
    assign rd_data = mem[rd_addr];

    function automatic logic [15:0] laneModel(input logic [15:0] x, input logic [15:0] k);
        logic signed [31:0] p;
        p = $signed(x) * $signed(k);
        return x[15] ? p[23:8] : x;
    endfunction

    always @(posedge clk) lr_out <= laneModel(lr_in, lr_leak);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " rd_en"}, rd_en, 0);
        checkOutput({tag, " rd_addr"}, rd_addr, 0);
        checkOutput({tag, " lr_in"}, lr_in, 0);
        checkOutput({tag, " lr_leak"}, lr_leak, 0);
        checkOutput({tag, " wr_en"}, wr_en, 0);
        checkOutput({tag, " wr_addr"}, wr_addr, 0);
    endtask

    task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dst,
                                 input logic [7:0] n, input logic we,
                                 input logic [15:0] leak);
        src_base = src;
        dst_base = dst;
        len      = n;
        cfg_we   = we;
        cfg_leak = leak;
        start    = 1'b1;
        nextCycle();
        start    = 1'b0;
        cfg_we   = 1'b0;
    endtask

    // Entered in cycle 1 of a command; leaves in the first IDLE cycle after done
    task automatic runCommand(input logic [7:0] src, input logic [7:0] dst,
                              input int n, input bit disturb);
        int doneCycle;
        logic [7:0] a;
        bit rdExp;
        bit wrExp;
        doneCycle = (n == 0) ? 1 : n + 3;
        for (int c = 1; c <= doneCycle + 1; c++) begin
            rdExp = (c <= n);
            wrExp = (c >= 3) && (c <= n + 2);
            checkOutput($sformatf("rd_en c%0d", c), rd_en, rdExp);
            if (rdExp) begin
                a = src + 8'(c - 1);
                checkOutput($sformatf("rd_addr c%0d", c), rd_addr, a);
            end
            checkOutput($sformatf("wr_en c%0d", c), wr_en, wrExp);
            if (wrExp) begin
                a = dst + 8'(c - 3);
                checkOutput($sformatf("wr_addr c%0d", c), wr_addr, a);
                checkOutput($sformatf("wr_data c%0d", c), wr_data, expData[c - 3]);
            end
            checkOutput($sformatf("done c%0d", c), done, (c == doneCycle));
            checkOutput($sformatf("busy c%0d", c), busy, (c <= doneCycle));
            if (c == doneCycle + 1) break;
            if (disturb) begin
                start    = 1'b1;
                src_base = 8'h80;
                len      = 8'd7;
                cfg_we   = 1'b1;
                cfg_leak = 16'h0100;
            end
            nextCycle();
        end
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_leak = '0;
        src_base = '0;
        dst_base = '0;
        len = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 16'h0100;
        mem[8'h11] = 16'hFE00;
        mem[8'h12] = 16'h0000;
        mem[8'h13] = 16'hFC00;
        mem[8'h20] = 16'hFE00;
        mem[8'h21] = 16'h0200;
        mem[8'h22] = 16'hFF00;
        mem[8'hFE] = 16'h0300;
        mem[8'hFF] = 16'hF800;
        mem[8'h00] = 16'h0001;
        mem[8'h50] = 16'hFF00;

        #2;
        checkReset("por");
        nextCycle();
        nextCycle();
        rst = 1'b0;
        nextCycle();

        cfg_we = 1'b1;
        cfg_leak = 16'h0080;
        nextCycle();
        cfg_we = 1'b0;
        checkOutput("lr_leak cfg", lr_leak, 16'h0080);

        expData[0] = 16'h0100;
        expData[1] = 16'hFF00;
        expData[2] = 16'h0000;
        expData[3] = 16'hFE00;
        applyStimulus(8'h10, 8'h40, 8'd4, 1'b0, 16'h0000);
        runCommand(8'h10, 8'h40, 4, 1'b0);

        applyStimulus(8'h33, 8'h44, 8'd0, 1'b0, 16'h0000);
        runCommand(8'h33, 8'h44, 0, 1'b0);

        expData[0] = 16'hFF00;
        expData[1] = 16'h0200;
        expData[2] = 16'hFF80;
        applyStimulus(8'h20, 8'h60, 8'd3, 1'b0, 16'h0000);
        runCommand(8'h20, 8'h60, 3, 1'b1);
        checkOutput("lr_leak after busy cfg", lr_leak, 16'h0080);

        expData[0] = 16'h0300;
        expData[1] = 16'hFE00;
        expData[2] = 16'h0001;
        applyStimulus(8'hFE, 8'hFF, 8'd3, 1'b1, 16'h0040);
        checkOutput("lr_leak same-cycle cfg", lr_leak, 16'h0040);
        runCommand(8'hFE, 8'hFF, 3, 1'b0);

        applyStimulus(8'h30, 8'h70, 8'd8, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("rd_en before abort", rd_en, 1);
        #3;
        rst = 1'b1;
        #1;
        checkReset("async");
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("done held reset", done, 0);
            checkOutput("rd_en held reset", rd_en, 0);
            checkOutput("wr_en held reset", wr_en, 0);
        end
        rst = 1'b0;
        nextCycle();
        checkOutput("lr_leak after abort", lr_leak, 0);

        expData[0] = 16'h0000;
        applyStimulus(8'h50, 8'h90, 8'd1, 1'b0, 16'h0000);
        runCommand(8'h50, 8'h90, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
